// File: rtl/mdom_trig_pkg.sv
// Shared constants and types for the multi-channel mDOM coincidence trigger.
// Trigger source codes, stream alignment depth and the channel FSM state type.
package mdom_trig_pkg;

    localparam logic [1:0] TRIG_SRC_THRESH = 2'd0;
    localparam logic [1:0] TRIG_SRC_EXT    = 2'd1;
    localparam logic [1:0] TRIG_SRC_SW     = 2'd2;
    localparam logic [1:0] TRIG_SRC_COINC  = 2'd3;

    // Samples are registered once, then the trigger decision is registered once more.
    localparam int STREAM_DELAY = 2;

    typedef enum logic [1:0] {
        ST_BELOW   = 2'd0,
        ST_PENDING = 2'd1,
        ST_ABOVE   = 2'd2
    } chan_state_t;

endpackage

// File: rtl/mdom_chan_thresh_fsm.sv
// Per-channel threshold discriminator with min-width qualification and hysteresis.
// fire is a combinational one-sample strobe; the parent registers it into trig.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_BELOW   | sample at or under threshold, armed
// ST_PENDING | sample over threshold, counting toward min_width
// ST_ABOVE   | fired; waits for sample <= max(thr-hyst,0) to re-arm
module mdom_chan_thresh_fsm
    import mdom_trig_pkg::*;
#(
    parameter int P_ADC_WIDTH = 12,
    parameter int P_MW_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [P_ADC_WIDTH-1:0] sample,
    input  logic [P_ADC_WIDTH-1:0] thr,
    input  logic [P_ADC_WIDTH-1:0] hyst,
    input  logic [P_MW_WIDTH-1:0]  min_width,
    input  logic                   enable,
    output logic                   fire,
    output logic                   tot
);

    chan_state_t             state, state_nx;
    logic [P_MW_WIDTH-1:0]   cnt, cnt_nx;
    logic [P_MW_WIDTH-1:0]   mw_eff;
    logic [P_MW_WIDTH:0]     cnt_inc;
    logic [P_ADC_WIDTH-1:0]  low_thr;
    logic                    over;
    logic                    under_low;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BELOW;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        fire      = 1'b0;
        mw_eff    = (min_width == '0) ? P_MW_WIDTH'(1) : min_width;
        cnt_inc   = {1'b0, cnt} + (P_MW_WIDTH+1)'(1);
        low_thr   = (thr > hyst) ? (thr - hyst) : '0;
        over      = (sample > thr);
        under_low = (sample <= low_thr);

        if (!enable) begin
            state_nx = ST_BELOW;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_BELOW: begin
                    if (over) begin
                        if (mw_eff == P_MW_WIDTH'(1)) begin
                            state_nx = ST_ABOVE;
                            fire     = 1'b1;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = ST_PENDING;
                            cnt_nx   = P_MW_WIDTH'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (!over) begin
                        state_nx = ST_BELOW;
                        cnt_nx   = '0;
                    end else if (cnt_inc >= {1'b0, mw_eff}) begin
                        // >= keeps a live min_width reduction from stranding the FSM here
                        state_nx = ST_ABOVE;
                        fire     = 1'b1;
                        cnt_nx   = '0;
                    end else if (cnt != '1) begin
                        cnt_nx = cnt_inc[P_MW_WIDTH-1:0];
                    end
                end
                ST_ABOVE: begin
                    if (under_low) begin
                        state_nx = ST_BELOW;
                    end
                end
                default: begin
                    state_nx = ST_BELOW;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign tot = (state != ST_BELOW);

endmodule

// File: rtl/mdom_coinc_trigger.sv
// N-channel mDOM trigger: threshold FSMs, M-of-N coincidence, sw/ext triggers,
// with ADC/discr streams delayed so each trig pulse lines up with its sample.
module mdom_coinc_trigger
    import mdom_trig_pkg::*;
#(
    parameter int P_N_CHAN      = 4,
    parameter int P_ADC_WIDTH   = 12,
    parameter int P_DISCR_WIDTH = 8,
    parameter int P_MW_WIDTH    = 4,
    parameter int P_WIN_WIDTH   = 6,
    localparam int MB           = $clog2(P_N_CHAN + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [P_N_CHAN*P_ADC_WIDTH-1:0]   adc_stream_in,
    input  logic [P_N_CHAN*P_DISCR_WIDTH-1:0] discr_stream_in,
    output logic [P_N_CHAN*P_ADC_WIDTH-1:0]   adc_stream_out,
    output logic [P_N_CHAN*P_DISCR_WIDTH-1:0] discr_stream_out,
    input  logic [P_N_CHAN*P_ADC_WIDTH-1:0]   thr,
    input  logic [P_ADC_WIDTH-1:0]            hyst,
    input  logic [P_MW_WIDTH-1:0]             min_width,
    input  logic [P_N_CHAN-1:0]               thresh_trig_en,
    input  logic                              coinc_en,
    input  logic [MB-1:0]                     coinc_mult,
    input  logic [P_WIN_WIDTH-1:0]            coinc_win,
    input  logic                              run,
    input  logic                              ext_run,
    input  logic                              ext_trig_en,
    output logic [P_N_CHAN-1:0]               trig,
    output logic [P_N_CHAN*2-1:0]             trig_src,
    output logic [P_N_CHAN-1:0]               thresh_tot
);

    logic [P_N_CHAN*P_ADC_WIDTH-1:0]   adc_pipe   [STREAM_DELAY];
    logic [P_N_CHAN*P_DISCR_WIDTH-1:0] discr_pipe [STREAM_DELAY];
    logic                              run_s1, run_q;
    logic                              ext_s1, ext_q;
    logic [P_WIN_WIDTH-1:0]            win_cnt [P_N_CHAN];
    logic [P_N_CHAN-1:0]               fire;
    logic [P_N_CHAN-1:0]               active;
    logic [MB-1:0]                     pop;
    logic [MB-1:0]                     m_eff;
    logic                              sw_rise, ext_rise, coinc_hit;
    logic [P_N_CHAN-1:0]               trig_nx;
    logic [P_N_CHAN*2-1:0]             src_nx;

    // Edge registers reset high so a level held through reset never fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STREAM_DELAY; i++) begin
                adc_pipe[i]   <= '0;
                discr_pipe[i] <= '0;
            end
            run_s1 <= 1'b1;
            run_q  <= 1'b1;
            ext_s1 <= 1'b1;
            ext_q  <= 1'b1;
        end else begin
            adc_pipe[0]   <= adc_stream_in;
            discr_pipe[0] <= discr_stream_in;
            for (int i = 1; i < STREAM_DELAY; i++) begin
                adc_pipe[i]   <= adc_pipe[i-1];
                discr_pipe[i] <= discr_pipe[i-1];
            end
            run_s1 <= run;
            run_q  <= run_s1;
            ext_s1 <= ext_run;
            ext_q  <= ext_s1;
        end
    end

    assign adc_stream_out   = adc_pipe[STREAM_DELAY-1];
    assign discr_stream_out = discr_pipe[STREAM_DELAY-1];

    for (genvar c = 0; c < P_N_CHAN; c++) begin : g_chan
        mdom_chan_thresh_fsm #(
            .P_ADC_WIDTH (P_ADC_WIDTH),
            .P_MW_WIDTH  (P_MW_WIDTH)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample    (adc_pipe[0][c*P_ADC_WIDTH +: P_ADC_WIDTH]),
            .thr       (thr[c*P_ADC_WIDTH +: P_ADC_WIDTH]),
            .hyst      (hyst),
            .min_width (min_width),
            .enable    (thresh_trig_en[c]),
            .fire      (fire[c]),
            .tot       (thresh_tot[c])
        );
    end

    always_comb begin
        sw_rise  = run_s1 & ~run_q;
        ext_rise = ext_trig_en & ext_s1 & ~ext_q;
        m_eff    = (coinc_mult == '0) ? MB'(1) : coinc_mult;
        pop      = '0;
        active   = '0;
        for (int c = 0; c < P_N_CHAN; c++) begin
            active[c] = fire[c] | (win_cnt[c] != '0);
            pop       = pop + MB'(active[c]);
        end
        coinc_hit = coinc_en & (pop >= m_eff);

        trig_nx = '0;
        src_nx  = '0;
        for (int c = 0; c < P_N_CHAN; c++) begin
            if (ext_rise) begin
                trig_nx[c]       = 1'b1;
                src_nx[c*2 +: 2] = TRIG_SRC_EXT;
            end else if (sw_rise) begin
                trig_nx[c]       = 1'b1;
                src_nx[c*2 +: 2] = TRIG_SRC_SW;
            end else if (coinc_hit) begin
                trig_nx[c]       = 1'b1;
                src_nx[c*2 +: 2] = TRIG_SRC_COINC;
            end else if (!coinc_en && fire[c]) begin
                trig_nx[c]       = 1'b1;
                src_nx[c*2 +: 2] = TRIG_SRC_THRESH;
            end
        end
    end

    // Windows are cleared on any coincidence, even when a higher-priority source wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < P_N_CHAN; c++) begin
                win_cnt[c] <= '0;
            end
            trig     <= '0;
            trig_src <= '0;
        end else begin
            for (int c = 0; c < P_N_CHAN; c++) begin
                if (!coinc_en || coinc_hit) begin
                    win_cnt[c] <= '0;
                end else if (fire[c]) begin
                    win_cnt[c] <= coinc_win;
                end else if (win_cnt[c] != '0) begin
                    win_cnt[c] <= win_cnt[c] - P_WIN_WIDTH'(1);
                end
            end
            trig     <= trig_nx;
            trig_src <= src_nx;
        end
    end

endmodule

// File: tb/tb_mdom_coinc_trigger.sv
// Scoreboard bench for mdom_coinc_trigger: directed spec scenarios followed by
// randomized traffic, checked against an event-level model of the trigger rules.
module tb_mdom_coinc_trigger;

    localparam int N   = 4;
    localparam int W   = 12;
    localparam int D   = 8;
    localparam int MWW = 4;
    localparam int WW  = 6;
    localparam int MB  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N*W-1:0]   adc_in, adc_out, thr;
    logic [N*D-1:0]   discr_in, discr_out;
    logic [W-1:0]     hyst;
    logic [MWW-1:0]   min_width;
    logic [N-1:0]     en;
    logic             coinc_en;
    logic [MB-1:0]    coinc_mult;
    logic [WW-1:0]    coinc_win;
    logic             run, ext_run, ext_trig_en;
    logic [N-1:0]     trig, tot;
    logic [2*N-1:0]   trig_src;

    mdom_coinc_trigger #(
        .P_N_CHAN(N), .P_ADC_WIDTH(W), .P_DISCR_WIDTH(D), .P_MW_WIDTH(MWW), .P_WIN_WIDTH(WW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .adc_stream_in(adc_in), .discr_stream_in(discr_in),
        .adc_stream_out(adc_out), .discr_stream_out(discr_out),
        .thr(thr), .hyst(hyst), .min_width(min_width), .thresh_trig_en(en),
        .coinc_en(coinc_en), .coinc_mult(coinc_mult), .coinc_win(coinc_win),
        .run(run), .ext_run(ext_run), .ext_trig_en(ext_trig_en),
        .trig(trig), .trig_src(trig_src), .thresh_tot(tot)
    );

    typedef struct {
        int           due;
        logic [N-1:0]   trig;
        logic [2*N-1:0] src;
        logic [N-1:0]   tot;
        logic [N*W-1:0] adc;
        logic [N*D-1:0] discr;
    } rec_t;

    rec_t sb[$];
    int   edge_n = 0;
    int   total = 0;
    int   bad = 0;
    int   trig_cnt[N];

    always @(posedge clk) edge_n <= edge_n + 1;

    // Model state: run of over-threshold samples, post-fire flag, coincidence expiry edge.
    int             run_len[N];
    bit             above[N];
    int             expiry[N];
    bit             prev_run = 1'b1, prev_ext = 1'b1;
    logic [N*W-1:0] p_adc = '0;
    logic [N*D-1:0] p_discr = '0;
    bit             p_rst = 1'b1, p_run = 1'b1, p_ext = 1'b1;

    // Expected outputs just after the coming clock edge: samples/edges from the previous
    // cycle's inputs, configuration and reset as they are now.
    task automatic model(output rec_t r);
        int d, s, t, lo, mw, nact, m;
        bit pr, pe, sw, ex, hit;
        bit fire[N];
        d = edge_n + 1;
        r.due = d; r.trig = '0; r.src = '0; r.tot = '0; r.adc = '0; r.discr = '0;
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                run_len[c] = 0; above[c] = 0; expiry[c] = -1;
            end
            prev_run = 1'b1;
            prev_ext = 1'b1;
        end else begin
            pr = p_rst ? 1'b1 : p_run;
            pe = p_rst ? 1'b1 : p_ext;
            mw = (min_width == 0) ? 1 : int'(min_width);
            for (int c = 0; c < N; c++) begin
                s  = p_rst ? 0 : int'(p_adc[c*W +: W]);
                t  = int'(thr[c*W +: W]);
                lo = (t > int'(hyst)) ? t - int'(hyst) : 0;
                fire[c] = 0;
                if (!en[c]) begin
                    run_len[c] = 0; above[c] = 0;
                end else if (above[c]) begin
                    if (s <= lo) above[c] = 0;
                end else if (s > t) begin
                    run_len[c]++;
                    if (run_len[c] >= mw) begin
                        fire[c] = 1; above[c] = 1; run_len[c] = 0;
                    end
                end else begin
                    run_len[c] = 0;
                end
                r.tot[c] = above[c] || (run_len[c] > 0);
            end
            sw = pr && !prev_run;
            ex = ext_trig_en && pe && !prev_ext;
            prev_run = pr;
            prev_ext = pe;
            hit = 0;
            if (coinc_en) begin
                nact = 0;
                for (int c = 0; c < N; c++) if (fire[c] || expiry[c] >= d) nact++;
                m   = (coinc_mult == 0) ? 1 : int'(coinc_mult);
                hit = (nact >= m);
                for (int c = 0; c < N; c++) begin
                    if (hit) expiry[c] = -1;
                    else if (fire[c]) expiry[c] = d + int'(coinc_win);
                end
            end else begin
                for (int c = 0; c < N; c++) expiry[c] = -1;
            end
            for (int c = 0; c < N; c++) begin
                if (ex)                        begin r.trig[c] = 1; r.src[c*2 +: 2] = 2'd1; end
                else if (sw)                   begin r.trig[c] = 1; r.src[c*2 +: 2] = 2'd2; end
                else if (hit)                  begin r.trig[c] = 1; r.src[c*2 +: 2] = 2'd3; end
                else if (!coinc_en && fire[c]) begin r.trig[c] = 1; r.src[c*2 +: 2] = 2'd0; end
            end
            r.adc   = p_rst ? '0 : p_adc;
            r.discr = p_rst ? '0 : p_discr;
        end
        p_adc   = adc_in;
        p_discr = discr_in;
        p_rst   = !rst_n;
        p_run   = run;
        p_ext   = ext_run;
    endtask

    task automatic step();
        rec_t r;
        discr_in = $urandom;
        model(r);
        sb.push_back(r);
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int c, input int v);
        adc_in[c*W +: W] = W'(v);
    endtask

    task automatic idle(input int n);
        adc_in = '0;
        repeat (n) step();
    endtask

    task automatic clr();
        for (int c = 0; c < N; c++) trig_cnt[c] = 0;
    endtask

    task automatic check_cnt(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: pulses got %0d expected %0d", name, act, exp_v);
        end
    endtask

    initial begin
        rec_t r;
        for (int c = 0; c < N; c++) trig_cnt[c] = 0;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due < edge_n) begin
                r = sb.pop_front();
                total++; bad++;
                $display("FAIL stale_record: due %0d at edge %0d", r.due, edge_n);
            end
            if (sb.size() > 0 && sb[0].due == edge_n) begin
                r = sb.pop_front();
                total++;
                if (trig !== r.trig || trig_src !== r.src || tot !== r.tot ||
                    adc_out !== r.adc || discr_out !== r.discr) begin
                    bad++;
                    $display("FAIL outputs@edge%0d: trig %b/%b src %h/%h tot %b/%b adc %h/%h discr %h/%h (got/exp)",
                             edge_n, trig, r.trig, trig_src, r.src, tot, r.tot,
                             adc_out, r.adc, discr_out, r.discr);
                end
            end
            for (int c = 0; c < N; c++) if (trig[c] === 1'b1) trig_cnt[c]++;
        end
    end

    int seq3[14] = '{101, 99, 95, 101, 101, 101, 95, 101, 101, 101, 90, 101, 101, 101};

    initial begin
        bit hi[N];
        int t, lo, k;
        rst_n = 1'b0; adc_in = '0; discr_in = '0;
        for (int c = 0; c < N; c++) thr[c*W +: W] = W'(100);
        hyst = W'(10); min_width = MWW'(3); en = '1;
        coinc_en = 1'b0; coinc_mult = '0; coinc_win = '0;
        run = 1'b0; ext_run = 1'b0; ext_trig_en = 1'b0;

        repeat (3) step();
        rst_n = 1'b1;
        idle(3);

        clr();
        set_ch(0, 101); repeat (3) step();
        idle(5);
        check_cnt("mw3_single_fire", trig_cnt[0], 1);

        clr();
        set_ch(0, 101); step(); step(); set_ch(0, 99); step();
        idle(5);
        check_cnt("mw3_short_pulse", trig_cnt[0], 0);

        clr();
        foreach (seq3[i]) begin set_ch(0, seq3[i]); step(); end
        idle(5);
        check_cnt("hysteresis_rearm", trig_cnt[0], 2);

        coinc_en = 1'b1; coinc_mult = MB'(2); coinc_win = WW'(4); min_width = MWW'(1);
        clr();
        set_ch(1, 101); step(); set_ch(1, 0); step(); step();
        set_ch(3, 101); step();
        idle(6);
        check_cnt("coinc_in_window", trig_cnt[0], 1);
        clr();
        set_ch(1, 101); step(); set_ch(1, 0); repeat (4) step();
        set_ch(3, 101); step();
        idle(6);
        check_cnt("coinc_out_of_window", trig_cnt[2], 0);

        coinc_en = 1'b0;
        clr();
        set_ch(2, 101); run = 1'b1; step();
        set_ch(2, 0); run = 1'b0; step();
        idle(2);
        ext_trig_en = 1'b1; ext_run = 1'b1; run = 1'b1; set_ch(2, 101); step();
        run = 1'b0; ext_run = 1'b0;
        idle(5);
        check_cnt("sw_ext_priority", trig_cnt[2], 2);

        clr();
        run = 1'b1; rst_n = 1'b0; repeat (3) step();
        rst_n = 1'b1; idle(5);
        check_cnt("run_held_through_reset", trig_cnt[0], 0);
        run = 1'b0; step(); run = 1'b1; idle(5);
        check_cnt("run_rise_after_reset", trig_cnt[3], 1);
        run = 1'b0; idle(2);

        clr();
        en = 4'b1011; min_width = MWW'(3);
        set_ch(2, 150); repeat (20) step();
        idle(5);
        check_cnt("disabled_channel", trig_cnt[2], 0);
        en = '1;

        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < N; c++) begin
                thr[c*W +: W] = W'($urandom_range(20, 300));
                hi[c] = 0;
            end
            hyst        = W'($urandom_range(0, 60));
            min_width   = MWW'($urandom_range(0, 5));
            en          = N'($urandom);
            coinc_en    = 1'($urandom);
            coinc_mult  = MB'($urandom_range(0, 5));
            coinc_win   = WW'($urandom_range(0, 7));
            ext_trig_en = 1'($urandom);
            repeat (250) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(0, 4) == 0) hi[c] = !hi[c];
                    t  = int'(thr[c*W +: W]);
                    lo = (t > int'(hyst)) ? t - int'(hyst) : 0;
                    k  = $urandom_range(0, 9);
                    if (hi[c])       set_ch(c, t + 1 + $urandom_range(0, 40));
                    else if (k == 0) set_ch(c, t);
                    else if (k == 1) set_ch(c, lo);
                    else if (k == 2) set_ch(c, lo + 1);
                    else             set_ch(c, $urandom_range(0, t));
                end
                if ($urandom_range(0, 7) == 0) run = !run;
                if ($urandom_range(0, 7) == 0) ext_run = !ext_run;
                rst_n = ($urandom_range(0, 149) != 0);
                step();
            end
            rst_n = 1'b1;
        end

        idle(4);
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
